// File: rtl/reg_file_wb.sv
// reg_file_wb: general register file and writeback stage with CPSR flags.
//
// A write is captured into a one-entry writeback stage on the edge where
// w_enable is high and committed to the array on the following edge. Reads
// are combinational and see the pending stage before the array, so a value is
// readable the cycle after capture. MOVT writes (w_hi_only) replace only the
// upper half and keep the lower half of the destination.
//
// Optional feature macro: REG_FILE_WB_BYPASS_EN
//   Defined   - a write presented this cycle is forwarded to matching read ports
//               at highest priority.
//   Undefined - the incoming write is invisible to reads until it has been
//               captured into the writeback stage.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   r_addr_0, r_addr_1   read addresses
//   r_val_0, r_val_1     combinational read data
//   w_enable, w_select   write request, source select (0 = ALU, 1 = ID)
//   w_addr               destination register
//   w_alu, w_id          candidate write data
//   w_hi_only            write upper half only (MOVT)
//   flags_we, flags_in   CPSR update request and new {N, C, Z, V}
//   flags                committed CPSR {N, C, Z, V}
//   wb_pending           writeback stage holds an uncommitted write

module reg_file_wb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NUM_REGS)-1:0] r_addr_0,
    input  logic [$clog2(NUM_REGS)-1:0] r_addr_1,
    output logic [DATA_W-1:0]           r_val_0,
    output logic [DATA_W-1:0]           r_val_1,
    input  logic                        w_enable,
    input  logic                        w_select,
    input  logic [$clog2(NUM_REGS)-1:0] w_addr,
    input  logic [DATA_W-1:0]           w_alu,
    input  logic [DATA_W-1:0]           w_id,
    input  logic                        w_hi_only,
    input  logic                        flags_we,
    input  logic [3:0]                  flags_in,
    output logic [3:0]                  flags,
    output logic                        wb_pending
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned HALF_W = DATA_W / 2;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_hi_q;
    logic [3:0]        flags_q;

    logic [DATA_W-1:0] w_data_in;
    logic [ADDR_W-1:0] rd_addr [2];

    assign w_data_in  = w_select ? w_id : w_alu;
    assign rd_addr[0] = r_addr_0;
    assign rd_addr[1] = r_addr_1;

    // Commit of the pending stage happens on the same edge that may capture a
    // new write, so back-to-back writes never stall and commit in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_hi_q    <= 1'b0;
            flags_q    <= '0;
        end else begin
            if (wb_valid_q) begin
                if (wb_hi_q) begin
                    regs_q[wb_addr_q][DATA_W-1:HALF_W] <= wb_data_q[DATA_W-1:HALF_W];
                end else begin
                    regs_q[wb_addr_q] <= wb_data_q;
                end
            end
            wb_valid_q <= w_enable;
            if (w_enable) begin
                wb_addr_q <= w_addr;
                wb_data_q <= w_data_in;
                wb_hi_q   <= w_hi_only;
            end
            if (flags_we) begin
                flags_q <= flags_in;
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_W-1:0] arr_val;
        logic [DATA_W-1:0] stage_val;
        logic [DATA_W-1:0] val;

        always_comb begin
            arr_val   = regs_q[rd_addr[p]];
            stage_val = arr_val;
            // A pending MOVT merges with the array value, which already holds
            // any earlier write to the same register.
            if (wb_valid_q && (wb_addr_q == rd_addr[p])) begin
                stage_val = wb_hi_q ? {wb_data_q[DATA_W-1:HALF_W], arr_val[HALF_W-1:0]}
                                    : wb_data_q;
            end
            val = stage_val;
`ifdef REG_FILE_WB_BYPASS_EN
            if (w_enable && (w_addr == rd_addr[p])) begin
                val = w_hi_only ? {w_data_in[DATA_W-1:HALF_W], stage_val[HALF_W-1:0]}
                                : w_data_in;
            end
`endif
        end
    end

    assign r_val_0    = g_rd[0].val;
    assign r_val_1    = g_rd[1].val;
    assign flags      = flags_q;
    assign wb_pending = wb_valid_q;

endmodule
